// File: rtl/score_keeper.sv
// Rhythm-game score keeper: judges each beat and tracks score, combo and best combo.
// Build option: define SCORE_COMBO_MULT_EN to scale hit points with the pre-hit combo.
module score_keeper #(
    parameter int SCORE_W      = 16,
    parameter int COMBO_W      = 8,
    parameter int HIT_POINTS   = 10,
    parameter int MISS_PENALTY = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               song_end,
    input  logic               beat_tick,
    input  logic               increase_score,
    input  logic               decrease_score,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo,
    output logic               playing,
    output logic               game_over,
    output logic               hit_pulse,
    output logic               miss_pulse
);

    localparam int PW = SCORE_W + 3;
    localparam int SW = SCORE_W + 4;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;
    localparam logic [SCORE_W-1:0] PENALTY   = SCORE_W'(MISS_PENALTY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [SCORE_W-1:0] score_q;
    logic [COMBO_W-1:0] combo_q;
    logic [COMBO_W-1:0] max_combo_q;
    logic               playing_q;
    logic               game_over_q;
    logic               hit_pulse_q;
    logic               miss_pulse_q;

    logic [SCORE_W-1:0] score_hit_d;
    logic [SCORE_W-1:0] score_miss_d;
    logic [COMBO_W-1:0] combo_hit_d;
    logic [COMBO_W-1:0] max_combo_hit_d;
    logic [2:0]         mult;
    logic [PW-1:0]      hit_add;
    logic [SW-1:0]      hit_sum;
    logic               judge_hit;
    logic               judge_miss;

`ifdef SCORE_COMBO_MULT_EN
    logic [31:0] combo_ext;
    assign combo_ext = 32'(combo_q);

    always_comb begin
        mult = 3'd1;
        if (combo_ext >= 32'd30) mult = 3'd4;
        else                     mult = 3'(32'd1 + combo_ext / 32'd10);
    end
`else
    assign mult = 3'd1;
`endif

    // Sum is kept one nibble wider than the score so overflow is visible before clamping.
    assign hit_add         = PW'(HIT_POINTS) * PW'(mult);
    assign hit_sum         = SW'(score_q) + SW'(hit_add);
    assign score_hit_d     = (hit_sum > SW'(SCORE_MAX)) ? SCORE_MAX : hit_sum[SCORE_W-1:0];
    assign score_miss_d    = (score_q > PENALTY) ? (score_q - PENALTY) : '0;
    assign combo_hit_d     = (combo_q == COMBO_MAX) ? combo_q : (combo_q + COMBO_W'(1));
    assign max_combo_hit_d = (combo_hit_d > max_combo_q) ? combo_hit_d : max_combo_q;

    assign judge_hit  = beat_tick &  increase_score & ~decrease_score;
    assign judge_miss = beat_tick & ~increase_score &  decrease_score;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            score_q      <= '0;
            combo_q      <= '0;
            max_combo_q  <= '0;
            playing_q    <= 1'b0;
            game_over_q  <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
        end else begin
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            if (start) begin
                // Start wins over song_end and any coincident beat in every state.
                state_q     <= ST_PLAY;
                score_q     <= '0;
                combo_q     <= '0;
                max_combo_q <= '0;
                playing_q   <= 1'b1;
                game_over_q <= 1'b0;
            end else if (state_q == ST_PLAY) begin
                if (judge_hit) begin
                    score_q     <= score_hit_d;
                    combo_q     <= combo_hit_d;
                    max_combo_q <= max_combo_hit_d;
                    hit_pulse_q <= 1'b1;
                end else if (judge_miss) begin
                    score_q      <= score_miss_d;
                    combo_q      <= '0;
                    miss_pulse_q <= 1'b1;
                end
                if (song_end) begin
                    state_q     <= ST_DONE;
                    playing_q   <= 1'b0;
                    game_over_q <= 1'b1;
                end
            end
        end
    end

    assign score      = score_q;
    assign combo      = combo_q;
    assign max_combo  = max_combo_q;
    assign playing    = playing_q;
    assign game_over  = game_over_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a default instance plus a narrow instance for saturation.
module tb_score_keeper;

    logic clk = 1'b0;
    logic resetn;
    logic start, song_end, beat_tick, inc, dec;

    logic [15:0] score;
    logic [7:0]  combo, max_combo;
    logic        playing, game_over, hit_pulse, miss_pulse;

    logic [6:0]  score_n;
    logic [3:0]  combo_n, max_combo_n;
    logic        playing_n, game_over_n, hit_pulse_n, miss_pulse_n;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    score_keeper dut (
        .clk(clk), .resetn(resetn), .start(start), .song_end(song_end),
        .beat_tick(beat_tick), .increase_score(inc), .decrease_score(dec),
        .score(score), .combo(combo), .max_combo(max_combo),
        .playing(playing), .game_over(game_over),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    score_keeper #(.SCORE_W(7), .COMBO_W(4), .HIT_POINTS(10), .MISS_PENALTY(5)) dut_n (
        .clk(clk), .resetn(resetn), .start(start), .song_end(song_end),
        .beat_tick(beat_tick), .increase_score(inc), .decrease_score(dec),
        .score(score_n), .combo(combo_n), .max_combo(max_combo_n),
        .playing(playing_n), .game_over(game_over_n),
        .hit_pulse(hit_pulse_n), .miss_pulse(miss_pulse_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic st, input logic se, input logic bt, input logic i, input logic d);
        start = st; song_end = se; beat_tick = bt; inc = i; dec = d;
        @(posedge clk);
        #1;
        start = 1'b0; song_end = 1'b0; beat_tick = 1'b0; inc = 1'b0; dec = 1'b0;
    endtask

    task automatic chk_main(input string tag, input int s, input int c, input int m);
        chk({tag, "_score"}, 32'(score), s);
        chk({tag, "_combo"}, 32'(combo), c);
        chk({tag, "_max"},   32'(max_combo), m);
    endtask

    task automatic chk_pulses(input string tag, input logic h, input logic mi);
        chk({tag, "_hit_pulse"},  32'(hit_pulse), 32'(h));
        chk({tag, "_miss_pulse"}, 32'(miss_pulse), 32'(mi));
    endtask

    initial begin
        int exp_s12, exp_s17;
`ifdef SCORE_COMBO_MULT_EN
        exp_s12 = 140;
        exp_s17 = 240;
`else
        exp_s12 = 120;
        exp_s17 = 170;
`endif
        resetn = 1'b0;
        start = 1'b0; song_end = 1'b0; beat_tick = 1'b0; inc = 1'b0; dec = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_main("por", 0, 0, 0);
        chk("por_playing", 32'(playing), 0);
        chk("por_game_over", 32'(game_over), 0);
        chk_pulses("por", 1'b0, 1'b0);
        resetn = 1'b1;
        cyc(0, 0, 0, 0, 0);

        // Test 1: reach score 40 / combo 3, then async reset mid-cycle.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        chk_main("t1_pre", 40, 3, 3);
        #2 resetn = 1'b0;
        #1;
        chk_main("t1_async", 0, 0, 0);
        chk("t1_async_playing", 32'(playing), 0);
        chk_pulses("t1_async", 1'b0, 1'b0);
        @(posedge clk);
        #1 resetn = 1'b1;
        cyc(0, 0, 1, 1, 0);
        chk_main("t1_idle_beat", 0, 0, 0);
        chk_pulses("t1_idle_beat", 1'b0, 1'b0);
        chk("t1_idle_playing", 32'(playing), 0);

        // Test 2: start and three hits, pulse exactly one cycle.
        cyc(1, 0, 0, 0, 0);
        chk("t2_playing", 32'(playing), 1);
        cyc(0, 0, 1, 1, 0);
        chk_main("t2_h1", 10, 1, 1);
        chk_pulses("t2_h1", 1'b1, 1'b0);
        cyc(0, 0, 0, 0, 0);
        chk_pulses("t2_h1_drop", 1'b0, 1'b0);
        cyc(0, 0, 1, 1, 0);
        chk_main("t2_h2", 20, 2, 2);
        chk_pulses("t2_h2", 1'b1, 1'b0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        chk_main("t2_h3", 30, 3, 3);
        cyc(0, 0, 0, 0, 0);
        chk_pulses("t2_h3_drop", 1'b0, 1'b0);

        // Test 3: miss then hit.
        cyc(0, 0, 1, 0, 1);
        chk_main("t3_miss", 25, 0, 3);
        chk_pulses("t3_miss", 1'b0, 1'b1);
        cyc(0, 0, 0, 0, 0);
        chk_pulses("t3_miss_drop", 1'b0, 1'b0);
        cyc(0, 0, 1, 1, 0);
        chk_main("t3_hit", 35, 1, 3);

        // Test 4: restart with coincident beat ignored, penalty floor, illegal input.
        cyc(1, 0, 1, 1, 0);
        chk_main("t4_restart", 0, 0, 0);
        chk_pulses("t4_restart", 1'b0, 1'b0);
        cyc(0, 0, 1, 0, 1);
        chk_main("t4_floor", 0, 0, 0);
        chk_pulses("t4_floor", 1'b0, 1'b1);
        cyc(0, 0, 1, 1, 0);
        chk_main("t4_hit", 10, 1, 1);
        cyc(0, 0, 1, 1, 1);
        chk_main("t4_both", 10, 1, 1);
        chk_pulses("t4_both", 1'b0, 1'b0);

        // Test 5: long hit run; narrow instance saturates combo and score.
        cyc(1, 0, 0, 0, 0);
        repeat (12) cyc(0, 0, 1, 1, 0);
        chk_main("t5_12", exp_s12, 12, 12);
        repeat (5) cyc(0, 0, 1, 1, 0);
        chk_main("t5_17", exp_s17, 17, 17);
        chk("t5_n_combo", 32'(combo_n), 15);
        chk("t5_n_max", 32'(max_combo_n), 15);
        chk("t5_n_score", 32'(score_n), 127);

        // Test 6: song end freezes, start restarts, start beats song_end, same-cycle beat judged.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 1, 0, 0, 0);
        chk("t6_end_game_over", 32'(game_over), 1);
        chk("t6_end_playing", 32'(playing), 0);
        cyc(0, 0, 1, 1, 0);
        chk_main("t6_frozen", 10, 1, 1);
        chk_pulses("t6_frozen", 1'b0, 1'b0);
        cyc(1, 1, 0, 0, 0);
        chk("t6_restart_playing", 32'(playing), 1);
        chk("t6_restart_game_over", 32'(game_over), 0);
        chk_main("t6_restart", 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 1, 1, 1, 0);
        chk_main("t6_end_beat", 20, 2, 2);
        chk_pulses("t6_end_beat", 1'b1, 1'b0);
        chk("t6_end_beat_game_over", 32'(game_over), 1);
        chk("t6_end_beat_playing", 32'(playing), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Consumer of the per-beat judgement pulses from the player-input judge (increase_score / decrease_score). Samples them on each beat strobe and maintains the running score, current combo and best combo. Runs a small game-state FSM (idle / playing / game over). Drives the score display, LEDs and sound triggers.

Parameters:
SCORE_W, 16, width of score accumulator (unsigned)
COMBO_W, 8, width of combo and max_combo counters (unsigned)
HIT_POINTS, 10, base points added per hit
MISS_PENALTY, 5, points subtracted per miss

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse: clear counters, begin song
song_end  in  1  1-cycle pulse: song finished, freeze results
beat_tick  in  1  1-cycle strobe: judgement window closes, sample judge outputs
increase_score  in  1  judge: player hit current note
decrease_score  in  1  judge: player missed current note
score  out  SCORE_W  running score
combo  out  COMBO_W  consecutive hits
max_combo  out  COMBO_W  best combo this song
playing  out  1  high in PLAY state
game_over  out  1  high in DONE state
hit_pulse  out  1  1-cycle pulse on accepted hit
miss_pulse  out  1  1-cycle pulse on accepted miss

Behaviour:
- Reset (resetn low, async): state IDLE; score, combo, max_combo = 0; playing, game_over, hit_pulse, miss_pulse = 0.
- All outputs registered; latency 1 cycle from the sampling edge to updated outputs.
- FSM states IDLE, PLAY, DONE:
  - IDLE --start--> PLAY.
  - PLAY --song_end--> DONE.
  - DONE --start--> PLAY.
  - start in PLAY: restart. Counters cleared, remain in PLAY.
  - start and song_end in the same cycle: start wins.
- Entering PLAY via start clears score, combo, max_combo. Any beat_tick in the same cycle is ignored.
- beat_tick is honoured only in PLAY. Ignored in IDLE and DONE; outputs hold.
- Judgement on beat_tick in PLAY, evaluated against pre-update register values:
  - Hit (increase_score=1, decrease_score=0):
    - score += HIT_POINTS * mult, saturating at 2^SCORE_W-1.
    - combo += 1, saturating at 2^COMBO_W-1.
    - max_combo = max(max_combo, new combo).
    - hit_pulse = 1 next cycle.
  - Miss (decrease_score=1, increase_score=0):
    - score -= MISS_PENALTY, floored at 0.
    - combo = 0.
    - max_combo unchanged.
    - miss_pulse = 1 next cycle.
  - Neither asserted (rest beat): no change, no pulses.
  - Both asserted (illegal from judge): no-op, no pulses.
- song_end with beat_tick in the same cycle: the beat is judged, then the FSM enters DONE.
- hit_pulse and miss_pulse are high for exactly one cycle and are never high together.
- Arithmetic: product HIT_POINTS*mult computed at SCORE_W+3 bits before saturation. No wrap-around anywhere.

Optional Feature:
Macro: SCORE_COMBO_MULT_EN
- Defined: mult = 1 + (combo_before_hit / 10), capped at 4.
  - combo 0–9 → x1, 10–19 → x2, 20–29 → x3, ≥30 → x4.
- Undefined: mult fixed at 1; no divider or compare logic is synthesised.

Test Plan:
1. Reset mid-PLAY with score=40, combo=3: resetn low → all outputs 0 immediately (async), state IDLE. beat_tick with increase_score=1 while in IDLE → no change.
2. start, then 3 beats with hit → score 10, 20, 30; combo 1, 2, 3; max_combo 3; one hit_pulse per beat, each 1 cycle after its beat_tick.
3. Continue from test 2 with 1 miss, then 1 hit → after the miss: score 25, combo 0, max_combo 3, miss_pulse once. After the hit: score 35, combo 1.
4. Penalty floor and illegal input, from fresh start:
   - Miss at score 0 → score stays 0.
   - Beat with both inputs high → no change, no pulses.
5. Combo saturation, with COMBO_W=4 and HIT_POINTS=10 overridden: 17 consecutive hits → combo saturates at 15, max_combo 15.
   - With SCORE_COMBO_MULT_EN defined, default params: 12 hits → score 140 (10×10 + 2×20), combo 12.
6. Song end and restart:
   - song_end → game_over=1, playing=0. Further hit beats → score frozen.
   - start → score 0, playing=1.
   - song_end with beat_tick+hit in the same cycle → hit counted, then game_over=1.
